pipelined_rca: RTL and testbench



---
 rtl/pipelined_rca.sv | 82 ++++++++
 tb/tb_pipelined_rca.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pipelined_rca.sv
// pipelined_rca: WIDTH-bit adder/subtractor resolving one SEG_WIDTH-bit carry segment per stage,
// with a valid/ready pipeline that stalls as a unit.
module pipelined_rca #(
    parameter int WIDTH     = 64,
    parameter int SEG_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NSEG = WIDTH / SEG_WIDTH;

    if (WIDTH % SEG_WIDTH != 0) begin : g_bad_width
        $error("pipelined_rca: WIDTH must be a multiple of SEG_WIDTH");
    end

    logic             v [NSEG];
    logic             c [NSEG];
    logic [WIDTH-1:0] x [NSEG];
    logic [WIDTH-1:0] y [NSEG];
    logic [WIDTH-1:0] s [NSEG];
    logic             advance;

    assign advance  = !v[NSEG-1] || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < NSEG; k++) begin : g_st
        logic             vi, ci;
        logic [WIDTH-1:0] xi, yi, si, so;
        logic [SEG_WIDTH:0] seg;
        if (k == 0) begin : g_first
            assign vi = in_valid;
            assign ci = cin ^ sub;
            assign xi = a;
            assign yi = sub ? ~b : b;
            assign si = '0;
        end else begin : g_next
            assign vi = v[k-1];
            assign ci = c[k-1];
            assign xi = x[k-1];
            assign yi = y[k-1];
            assign si = s[k-1];
        end
        assign seg = {1'b0, xi[k*SEG_WIDTH +: SEG_WIDTH]} + {1'b0, yi[k*SEG_WIDTH +: SEG_WIDTH]}
                   + {{SEG_WIDTH{1'b0}}, ci};
        always_comb begin
            so = si;
            so[k*SEG_WIDTH +: SEG_WIDTH] = seg[SEG_WIDTH-1:0];
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v[k] <= 1'b0;
                c[k] <= 1'b0;
                x[k] <= '0;
                y[k] <= '0;
                s[k] <= '0;
            end else if (advance) begin
                v[k] <= vi;
                c[k] <= seg[SEG_WIDTH];
                x[k] <= xi;
                y[k] <= yi;
                s[k] <= so;
            end
        end
    end

    assign out_valid = v[NSEG-1];
    assign sum       = s[NSEG-1];
    assign cout      = c[NSEG-1];
    // carry into the MSB is recovered from the MSB sum bit and its operand bits
    assign ovf       = c[NSEG-1] ^ x[NSEG-1][WIDTH-1] ^ y[NSEG-1][WIDTH-1] ^ s[NSEG-1][WIDTH-1];
endmodule

// File: tb/tb_pipelined_rca.sv
// tb_pipelined_rca: random and directed stimulus checked against a queue-based arithmetic model.
module tb_pipelined_rca;
    localparam int W = 64;
    localparam int L = 4;

    logic         clk = 0, rst_n = 1, in_valid = 0, cin = 0, sub = 0, out_ready = 1;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid, cout, ovf;
    logic [W-1:0] sum;

    pipelined_rca #(.WIDTH(W), .SEG_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } res_t;

    int   n_cmp = 0, n_bad = 0;
    res_t q[$];
    res_t held;
    logic was_stalled = 0;

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb);
        logic [W:0]   t;
        logic [W-1:0] yy;
        res_t         r;
        yy  = sb ? ~y : y;
        t   = {1'b0, x} + {1'b0, yy} + (W+1)'(ci ^ sb);
        r.s = t[W-1:0];
        r.c = t[W];
        r.o = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: handshakes are judged at the negedge, where they are stable until the next edge
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            was_stalled = 0;
            check("reset_outputs", {out_valid, sum, cout, ovf, in_ready}, {1'b0, {W{1'b0}}, 1'b0, 1'b0, 1'b1});
        end else begin
            check("ready_rule", in_ready, !out_valid || out_ready);
            if (was_stalled) check("hold_stable", {out_valid, sum, cout, ovf}, {1'b1, held});
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_out: got out_valid=1 expected no pending result");
                end else if (out_ready) begin
                    check("result", {sum, cout, ovf}, q.pop_front());
                end
            end
            was_stalled = out_valid && !out_ready;
            held = {sum, cout, ovf};
            if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb);
        int k;
        in_valid = 1; a = x; b = y; cin = ci; sub = sb;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k == 50) check("send_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        if (k == 100) check("drain_timeout", 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic lit(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb,
                       input logic [W-1:0] es, input logic ec, input logic eo);
        int n;
        send(x, y, ci, sb);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        check("lit_latency", n, L);
        check("lit_result", {sum, cout, ovf}, {es, ec, eo});
        drain();
    endtask

    initial begin
        check("model_ripple", model('1, '0, 1'b1, 1'b0), {{W{1'b0}}, 1'b1, 1'b0});
        check("model_sub", model(5, 7, 1'b0, 1'b1), {64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0});
        check("model_ovf", model(64'h7FFF_FFFF_FFFF_FFFF, 1, 1'b0, 1'b0), {64'h8000_0000_0000_0000, 1'b0, 1'b1});
        #2 rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        repeat (10) begin
            @(negedge clk);
            check("idle_valid", {out_valid, sum, in_ready}, {1'b0, {W{1'b0}}, 1'b1});
        end
        @(posedge clk);
        #1;
        lit('1, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        lit(5, 7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        lit(64'h7FFF_FFFF_FFFF_FFFF, 1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        lit(10, 3, 1'b1, 1'b1, 6, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) send($urandom_range(0, 100), $urandom_range(0, 100), 1'($urandom), 1'b0);
        drain();
        for (int i = 0; i < 30; i++) send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
        drain();
        fork
            for (int i = 0; i < 8; i++) send({$urandom, $urandom}, $urandom_range(0, 100), 1'($urandom), 1'($urandom));
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 1'b0);
                end
                @(posedge clk);
                #1 out_ready = 1;
            end
        join
        drain();
        for (int i = 0; i < 40; i++) begin
            out_ready = 1'($urandom_range(0, 3) != 0);
            in_valid = 1'($urandom);
            a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom); sub = 1'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        out_ready = 1;
        drain();
        for (int i = 0; i < 3; i++) send($urandom_range(0, 100), $urandom_range(0, 100), 1'b0, 1'b0);
        rst_n = 0;
        @(posedge clk);
        #1 rst_n = 1;
        repeat (10) begin
            @(negedge clk);
            check("post_reset_idle", out_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        lit(1, 2, 1'b0, 1'b0, 3, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
